sigmoid_lookup_ctrl: RTL and testbench

- Initiator side of the 1024x16 sigmoid LUT RAM port (en/we/addr/di/dout, dout registered, 1-cycle read latency).
- Accepts signed Q8.8 pre-activations on a valid/ready stream and quantizes/saturates each to a LUT address.
- Issues the RAM read, captures dout and presents the activation on a valid/ready output stream.
- Also provides a sequential table-load path that writes the whole LUT through the RAM write port.

---
 rtl/sigmoid_lookup_ctrl.sv | 157 +++++++++++++++
 tb/tb_sigmoid_lookup_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_lookup_ctrl.sv
// Initiator for a 1024x16 sigmoid LUT RAM: quantizes Q8.8 pre-activations into LUT reads
// over valid/ready streams, and streams a full table into the RAM through its write port.
module sigmoid_lookup_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int SHIFT  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and data is held stable while valid is 1 and ready is 0.
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_done_o,
    output logic              busy_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_di_o,
    input  logic [DATA_W-1:0] ram_dout_i
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic signed [DATA_W-1:0] S_MAX = DATA_W'((2 ** (ADDR_W - 1)) - 1);
    localparam logic signed [DATA_W-1:0] S_MIN = DATA_W'(-(2 ** (ADDR_W - 1)));
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(DEPTH / 2);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_WAIT,
        ST_CAPTURE,
        ST_HOLD,
        ST_LOAD
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                load_done_q, load_done_d;

    logic signed [DATA_W-1:0] shifted;
    logic signed [DATA_W-1:0] clamped;
    logic [ADDR_W-1:0]        lut_addr;

    logic              in_ready_c, load_ready_c;
    logic              ram_en_c, ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_di_c;

    // Saturate before offsetting so out-of-range inputs pin to the table ends instead of wrapping.
    always_comb begin
        shifted = $signed(in_data_i) >>> SHIFT;
        clamped = shifted;
        if (shifted > S_MAX) begin
            clamped = S_MAX;
        end else if (shifted < S_MIN) begin
            clamped = S_MIN;
        end
        lut_addr = clamped[ADDR_W-1:0] + HALF;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        load_done_d  = 1'b0;
        in_ready_c   = 1'b0;
        load_ready_c = 1'b0;
        ram_en_c     = 1'b0;
        ram_we_c     = 1'b0;
        ram_addr_c   = '0;
        ram_di_c     = '0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = !load_start_i;
                if (load_start_i) begin
                    state_d = ST_LOAD;
                end else if (in_valid_i) begin
                    ram_en_c   = 1'b1;
                    ram_addr_c = lut_addr;
                    state_d    = ST_ISSUE_WAIT;
                end
            end
            ST_ISSUE_WAIT: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                out_data_d  = ram_dout_i;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_ready_c = 1'b1;
                if (load_valid_i) begin
                    ram_en_c   = 1'b1;
                    ram_we_c   = 1'b1;
                    ram_addr_c = cnt_q;
                    ram_di_c   = load_data_i;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        load_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            load_done_q <= load_done_d;
        end
    end

    // Gate the RAM strobes with reset so a beat coinciding with reset never reaches the table.
    assign ram_en_o     = ram_en_c && !reset_i;
    assign ram_we_o     = ram_we_c && !reset_i;
    assign ram_addr_o   = reset_i ? '0 : ram_addr_c;
    assign ram_di_o     = reset_i ? '0 : ram_di_c;
    assign in_ready_o   = in_ready_c && !reset_i;
    assign load_ready_o = load_ready_c && !reset_i;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign load_done_o  = load_done_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sigmoid_lookup_ctrl.sv
// Bench for sigmoid_lookup_ctrl: behavioural RAM, a table model with an expected-result queue,
// one negedge compare process, and directed vectors with literal expectations.
module tb_sigmoid_lookup_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic              load_start_i;
    logic              load_valid_i;
    logic              load_ready_o;
    logic [DATA_W-1:0] load_data_i;
    logic              load_done_o;
    logic              busy_o;
    logic              ram_en_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_di_o;
    logic [DATA_W-1:0] ram_dout;

    // clock / reset
    always #5 clk = ~clk;

    sigmoid_lookup_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SHIFT(2)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .load_start_i (load_start_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_data_i  (load_data_i),
        .load_done_o  (load_done_o),
        .busy_o       (busy_o),
        .ram_en_o     (ram_en_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_di_o     (ram_di_o),
        .ram_dout_i   (ram_dout)
    );

    // LUT RAM with registered read data
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) ram[ram_addr_o] <= ram_di_o;
            else          ram_dout <= ram[ram_addr_o];
        end
    end

    // model and scoreboard state
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_out;
    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int wr_exp_addr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Q8.8 value / 4, floored, clamped to [-512, 511], offset by 512.
    function automatic int lut_index(input logic [DATA_W-1:0] d);
        int v;
        int s;
        v = int'($signed(d));
        s = v >>> 2;
        if (s > 511)  s = 511;
        if (s < -512) s = -512;
        return s + 512;
    endfunction

    // compare process
    always @(negedge clk) begin
        if (!reset_i) begin
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    check("out_data", out_data_o, exp_q[0]);
                    if (out_ready_i) begin
                        last_out = out_data_o;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (ram_en_o && ram_we_o) begin
                check("wr_addr", ram_addr_o, wr_exp_addr);
                check("wr_data", ram_di_o, wr_exp_addr);
                wr_exp_addr = (wr_exp_addr + 1) % DEPTH;
                wr_cnt++;
            end
            if (ram_en_o && !ram_we_o) rd_cnt++;
            if (load_done_o) done_cnt++;
        end
    end

    // driver tasks
    task automatic send_in(input logic [DATA_W-1:0] d);
        int t;
        t = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        @(negedge clk);
        while (!in_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_o) fail_now("in_accept_timeout");
        else exp_q.push_back(exp_mem[lut_index(d)]);
        @(posedge clk);
        #1 in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        #1;
    endtask

    task automatic read_check(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] lit);
        send_in(d);
        drain();
        check($sformatf("read_lit_%h", d), last_out, lit);
    endtask

    task automatic load_table(input int n, input bit gaps);
        load_start_i = 1'b1;
        @(posedge clk);
        #1 load_start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 7 == 6)) begin
                load_valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            load_valid_i = 1'b1;
            load_data_i  = DATA_W'(i);
            exp_mem[i]   = DATA_W'(i);
            if (i == 0) begin
                @(negedge clk);
                check("load_ready", load_ready_o, 1);
            end
            @(posedge clk);
            #1;
        end
        load_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        reset_i = 1'b1;
        in_valid_i = 1'b0;
        in_data_i = '0;
        out_ready_i = 1'b1;
        load_start_i = 1'b0;
        load_valid_i = 1'b0;
        load_data_i = '0;
        ram_dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 16'h5A00 ^ DATA_W'(i);
            exp_mem[i] = 16'h5A00 ^ DATA_W'(i);
        end
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_load_done", load_done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ram_en", ram_en_o, 0);
        check("rst_ram_we", ram_we_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_load_ready", load_ready_o, 0);
        @(posedge clk);
        #1;

        // load aborted by reset on beat 300
        load_table(300, 1'b0);
        load_valid_i = 1'b1;
        load_data_i  = 16'd300;
        reset_i      = 1'b1;
        @(negedge clk);
        check("abort_ram_en", ram_en_o, 0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        load_valid_i = 1'b0;
        wr_exp_addr = 0;
        @(negedge clk);
        check("abort_out_valid", out_valid_o, 0);
        check("abort_out_data", out_data_o, 0);
        check("abort_load_done", load_done_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_ram_en2", ram_en_o, 0);
        check("abort_ram_addr", ram_addr_o, 0);
        check("abort_ram_di", ram_di_o, 0);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_wr_cnt", wr_cnt, 300);
        @(posedge clk);
        #1;
        read_check(16'h0000, 16'h5800);
        read_check(16'h8000, 16'h0000);

        // full ramp with valid gaps
        wr_cnt = 0;
        done_cnt = 0;
        load_table(DEPTH, 1'b1);
        @(negedge clk);
        check("ramp_done_pulse", load_done_o, 1);
        check("ramp_busy_fall", busy_o, 0);
        @(negedge clk);
        check("ramp_done_low", load_done_o, 0);
        check("ramp_wr_cnt", wr_cnt, DEPTH);
        check("ramp_done_cnt", done_cnt, 1);
        @(posedge clk);
        #1;

        read_check(16'h0000, 16'd512);
        read_check(16'h0100, 16'd576);
        read_check(16'hFFFF, 16'd511);
        read_check(16'hFF00, 16'd448);
        read_check(16'h7FFF, 16'd1023);
        read_check(16'h8000, 16'd0);
        read_check(16'h0800, 16'd1023);

        // latency and backpressure
        out_ready_i = 1'b0;
        send_in(16'h0100);
        @(negedge clk);
        check("lat_issue_wait", out_valid_o, 0);
        check("lat_in_ready1", in_ready_o, 0);
        @(negedge clk);
        check("lat_capture", out_valid_o, 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", out_valid_o, 1);
            check("hold_data", out_data_o, 576);
            check("hold_in_ready", in_ready_o, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_out_valid_low", out_valid_o, 0);
        check("bp_in_ready", in_ready_o, 1);
        check("bp_busy", busy_o, 0);
        check("bp_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // simultaneous load start and input
        rd0 = rd_cnt;
        load_start_i = 1'b1;
        in_valid_i   = 1'b1;
        in_data_i    = 16'h0000;
        @(negedge clk);
        check("sim_in_ready", in_ready_o, 0);
        check("sim_ram_en", ram_en_o, 0);
        @(posedge clk);
        #1 load_start_i = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        check("sim_busy", busy_o, 1);
        check("sim_load_ready", load_ready_o, 1);
        check("sim_no_read", rd_cnt, rd0);
        @(posedge clk);
        #1;
        wr_cnt = 0;
        done_cnt = 0;
        load_table(DEPTH, 1'b0);
        @(negedge clk);
        check("sim_done_pulse", load_done_o, 1);
        check("sim_wr_cnt", wr_cnt, DEPTH);
        check("sim_no_read2", rd_cnt, rd0);
        @(posedge clk);
        #1;
        read_check(16'h0100, 16'd576);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
